// File: rtl/mips_cpu_lsu_if.sv
// mips_cpu_lsu_if: request/response and data-bus bundle for the LSU.
// slave = LSU side; master = execute stage plus data memory side.
interface mips_cpu_lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic [5:0]  req_opcode;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] req_rt_old;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] data_address;
  logic        data_read;
  logic        data_write;
  logic [31:0] data_writedata;
  logic [31:0] data_readdata;

  modport slave (
    input  req_valid,
    input  req_opcode,
    input  req_addr,
    input  req_wdata,
    input  req_rt_old,
    input  data_readdata,
    output req_ready,
    output resp_valid,
    output resp_rdata,
    output resp_err,
    output data_address,
    output data_read,
    output data_write,
    output data_writedata
  );

  modport master (
    output req_valid,
    output req_opcode,
    output req_addr,
    output req_wdata,
    output req_rt_old,
    output data_readdata,
    input  req_ready,
    input  resp_valid,
    input  resp_rdata,
    input  resp_err,
    input  data_address,
    input  data_read,
    input  data_write,
    input  data_writedata
  );
endinterface

// File: rtl/mips_cpu_lsu.sv
// mips_cpu_lsu: MIPS load/store unit, one request at a time.
// Ports: clk, reset (sync, active-high), bus (mips_cpu_lsu_if.slave).
module mips_cpu_lsu (
  input logic           clk,
  input logic           reset,
  mips_cpu_lsu_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, RD, CAP, WR, RESP
  } state_t;

  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LWL = 6'b100010;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_LWR = 6'b100110;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SW  = 6'b101011;

  state_t      state_q, state_d;
  logic [5:0]  op_q, op_d;
  logic [1:0]  off_q, off_d;
  logic [31:0] rt_q, rt_d;
  logic        req_ready_q, req_ready_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        resp_err_q, resp_err_d;
  logic [31:0] data_address_q, data_address_d;
  logic        data_read_q, data_read_d;
  logic        data_write_q, data_write_d;
  logic [31:0] data_wdata_q, data_wdata_d;

  logic        fire;
  logic        req_legal;
  logic        req_load;
  logic        req_sw;
  logic        req_mis;
  logic        req_err;
  logic [31:0] word;
  logic [7:0]  byte_k;
  logic [15:0] half_k;
  logic [31:0] ld_res;
  logic [31:0] merged;
  logic        sub_store;

  assign fire = bus.req_valid && req_ready_q;

  always_comb begin
    req_legal = 1'b1;
    req_load  = 1'b0;
    req_sw    = 1'b0;
    req_mis   = 1'b0;
    unique case (bus.req_opcode)
      OP_LB, OP_LBU, OP_LWL, OP_LWR: begin
        req_load = 1'b1;
      end
      OP_LH, OP_LHU: begin
        req_load = 1'b1;
        req_mis  = bus.req_addr[0];
      end
      OP_LW: begin
        req_load = 1'b1;
        req_mis  = |bus.req_addr[1:0];
      end
      OP_SB: begin
        req_mis = 1'b0;
      end
      OP_SH: begin
        req_mis = bus.req_addr[0];
      end
      OP_SW: begin
        req_sw  = 1'b1;
        req_mis = |bus.req_addr[1:0];
      end
      default: begin
        req_legal = 1'b0;
      end
    endcase
    req_err = !req_legal || req_mis;
  end

  assign word   = bus.data_readdata;
  assign byte_k = word[{off_q, 3'b000} +: 8];
  assign half_k = off_q[1] ? word[31:16] : word[15:0];

  // LWL/LWR merge the loaded word with the old rt per byte offset.
  always_comb begin
    ld_res = word;
    unique case (op_q)
      OP_LB:  ld_res = {{24{byte_k[7]}}, byte_k};
      OP_LBU: ld_res = {24'h0, byte_k};
      OP_LH:  ld_res = {{16{half_k[15]}}, half_k};
      OP_LHU: ld_res = {16'h0, half_k};
      OP_LWL: begin
        unique case (off_q)
          2'd0:    ld_res = {word[7:0], rt_q[23:0]};
          2'd1:    ld_res = {word[15:0], rt_q[15:0]};
          2'd2:    ld_res = {word[23:0], rt_q[7:0]};
          default: ld_res = word;
        endcase
      end
      OP_LWR: begin
        unique case (off_q)
          2'd0:    ld_res = word;
          2'd1:    ld_res = {rt_q[31:24], word[31:8]};
          2'd2:    ld_res = {rt_q[31:16], word[31:16]};
          default: ld_res = {rt_q[31:8], word[31:24]};
        endcase
      end
      default: ld_res = word;
    endcase
  end

  // Store data sits in data_wdata_q until the read-modify-write merge.
  always_comb begin
    merged = word;
    if (op_q == OP_SB) begin
      merged[{off_q, 3'b000} +: 8] = data_wdata_q[7:0];
    end else if (off_q[1]) begin
      merged[31:16] = data_wdata_q[15:0];
    end else begin
      merged[15:0] = data_wdata_q[15:0];
    end
  end

  assign sub_store = (op_q == OP_SB) || (op_q == OP_SH);

  always_comb begin
    state_d        = state_q;
    op_d           = op_q;
    off_d          = off_q;
    rt_d           = rt_q;
    resp_rdata_d   = resp_rdata_q;
    resp_err_d     = resp_err_q;
    data_address_d = data_address_q;
    data_wdata_d   = data_wdata_q;
    unique case (state_q)
      IDLE: begin
        if (fire) begin
          op_d         = bus.req_opcode;
          off_d        = bus.req_addr[1:0];
          rt_d         = bus.req_rt_old;
          resp_rdata_d = 32'h0;
          resp_err_d   = req_err;
          if (req_err) begin
            state_d = RESP;
          end else begin
            data_address_d = {bus.req_addr[31:2], 2'b00};
            if (!req_load) begin
              data_wdata_d = bus.req_wdata;
            end
            state_d = req_sw ? WR : RD;
          end
        end
      end
      RD: begin
        state_d = CAP;
      end
      CAP: begin
        if (sub_store) begin
          data_wdata_d = merged;
          state_d      = WR;
        end else begin
          resp_rdata_d = ld_res;
          state_d      = RESP;
        end
      end
      WR: begin
        state_d = RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Strobes are registered, decoded from the state being entered.
    req_ready_d  = state_d == IDLE;
    data_read_d  = state_d == RD;
    data_write_d = state_d == WR;
    resp_valid_d = state_d == RESP;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      op_q           <= 6'h0;
      off_q          <= 2'h0;
      rt_q           <= 32'h0;
      req_ready_q    <= 1'b0;
      resp_valid_q   <= 1'b0;
      resp_rdata_q   <= 32'h0;
      resp_err_q     <= 1'b0;
      data_address_q <= 32'h0;
      data_read_q    <= 1'b0;
      data_write_q   <= 1'b0;
      data_wdata_q   <= 32'h0;
    end else begin
      state_q        <= state_d;
      op_q           <= op_d;
      off_q          <= off_d;
      rt_q           <= rt_d;
      req_ready_q    <= req_ready_d;
      resp_valid_q   <= resp_valid_d;
      resp_rdata_q   <= resp_rdata_d;
      resp_err_q     <= resp_err_d;
      data_address_q <= data_address_d;
      data_read_q    <= data_read_d;
      data_write_q   <= data_write_d;
      data_wdata_q   <= data_wdata_d;
    end
  end

  assign bus.req_ready      = req_ready_q;
  assign bus.resp_valid     = resp_valid_q;
  assign bus.resp_rdata     = resp_rdata_q;
  assign bus.resp_err       = resp_err_q;
  assign bus.data_address   = data_address_q;
  assign bus.data_read      = data_read_q;
  assign bus.data_write     = data_write_q;
  assign bus.data_writedata = data_wdata_q;

endmodule

// File: tb/tb_mips_cpu_lsu.sv
// tb_mips_cpu_lsu: directed vector bench for mips_cpu_lsu.
// Table of requests with expected results plus reset corner cases.
module tb_mips_cpu_lsu;

  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LWL = 6'b100010;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_LWR = 6'b100110;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SW  = 6'b101011;

  typedef struct {
    logic [5:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rt;
    logic [31:0] mem;
    logic [31:0] rdata;
    logic [31:0] err;
    int          lat;
    int          rd;
    int          wr;
    logic [31:0] wd;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mips_cpu_lsu_if bif ();

  mips_cpu_lsu dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
  );

  int   n_cmp = 0;
  int   n_bad = 0;
  vec_t vq[$];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic [5:0] op, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [31:0] rt,
                     input logic [31:0] mem, input logic [31:0] rdata,
                     input logic [31:0] err, input int lat,
                     input int rd, input int wr, input logic [31:0] wd);
    vec_t t;
    t.op = op; t.addr = addr; t.wdata = wdata; t.rt = rt;
    t.mem = mem; t.rdata = rdata; t.err = err; t.lat = lat;
    t.rd = rd; t.wr = wr; t.wd = wd;
    vq.push_back(t);
  endtask

  task automatic run_vec(input vec_t t, input int idx);
    string       p;
    logic        rd_prev;
    int          rd_n, wr_n, rs_n, both, rd_c, wr_c, rs_c;
    logic [31:0] rd_a, wr_a, wr_d, rs_d, rs_e;
    p = $sformatf("v%0d", idx);
    rd_prev = 1'b0;
    rd_n = 0; wr_n = 0; rs_n = 0; both = 0;
    rd_c = 0; wr_c = 0; rs_c = 0;
    rd_a = 0; wr_a = 0; wr_d = 0; rs_d = 0; rs_e = 0;
    @(negedge clk);
    check({p, "_ready"}, 32'(bif.req_ready), 32'd1);
    bif.req_opcode = t.op;
    bif.req_addr   = t.addr;
    bif.req_wdata  = t.wdata;
    bif.req_rt_old = t.rt;
    bif.req_valid  = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk);
      #1;
      if (c == 1) bif.req_valid = 1'b0;
      bif.data_readdata = rd_prev ? t.mem : 32'hBAADF00D;
      @(negedge clk);
      rd_prev = bif.data_read;
      if (bif.data_read) begin
        rd_n++; rd_c = c; rd_a = bif.data_address;
      end
      if (bif.data_write) begin
        wr_n++; wr_c = c; wr_a = bif.data_address;
        wr_d = bif.data_writedata;
      end
      if (bif.data_read && bif.data_write) both++;
      if (bif.resp_valid) begin
        rs_n++; rs_c = c; rs_d = bif.resp_rdata;
        rs_e = 32'(bif.resp_err);
      end
    end
    check({p, "_resp_count"}, 32'(rs_n), 32'd1);
    check({p, "_resp_cycle"}, 32'(rs_c), 32'(t.lat));
    check({p, "_rdata"}, rs_d, t.rdata);
    check({p, "_err"}, rs_e, t.err);
    check({p, "_read_count"}, 32'(rd_n), 32'(t.rd));
    if (t.rd != 0) begin
      check({p, "_read_cycle"}, 32'(rd_c), 32'd1);
      check({p, "_read_addr"}, rd_a, {t.addr[31:2], 2'b00});
    end
    check({p, "_write_count"}, 32'(wr_n), 32'(t.wr));
    if (t.wr != 0) begin
      check({p, "_write_cycle"}, 32'(wr_c), 32'(t.lat - 1));
      check({p, "_write_addr"}, wr_a, {t.addr[31:2], 2'b00});
      check({p, "_write_data"}, wr_d, t.wd);
    end
    check({p, "_rd_wr_overlap"}, 32'(both), 32'd0);
    check({p, "_rdata_hold"}, bif.resp_rdata, t.rdata);
    check({p, "_err_hold"}, 32'(bif.resp_err), t.err);
  endtask

  initial begin
    int wr_n, rs_n;
    vec_t t;
    bif.req_valid     = 1'b0;
    bif.req_opcode    = 6'h0;
    bif.req_addr      = 32'h0;
    bif.req_wdata     = 32'h0;
    bif.req_rt_old    = 32'h0;
    bif.data_readdata = 32'h0;

    // loads: rdata, err, lat, rd, wr, wd
    add(OP_LW,  32'h100, 0, 0, 32'hDEADBEEF, 32'hDEADBEEF, 0, 3, 1, 0, 0);
    add(OP_LB,  32'h103, 0, 0, 32'h80112233, 32'hFFFFFF80, 0, 3, 1, 0, 0);
    add(OP_LBU, 32'h103, 0, 0, 32'h80112233, 32'h00000080, 0, 3, 1, 0, 0);
    add(OP_LB,  32'h101, 0, 0, 32'h80112233, 32'h00000022, 0, 3, 1, 0, 0);
    add(OP_LH,  32'h102, 0, 0, 32'h80112233, 32'hFFFF8011, 0, 3, 1, 0, 0);
    add(OP_LHU, 32'h102, 0, 0, 32'h80112233, 32'h00008011, 0, 3, 1, 0, 0);
    add(OP_LH,  32'h100, 0, 0, 32'h1234F00D, 32'hFFFFF00D, 0, 3, 1, 0, 0);
    add(OP_LWL, 32'h201, 0, 32'h11223344, 32'hAABBCCDD,
        32'hCCDD3344, 0, 3, 1, 0, 0);
    add(OP_LWR, 32'h201, 0, 32'h11223344, 32'hAABBCCDD,
        32'h11AABBCC, 0, 3, 1, 0, 0);
    add(OP_LWL, 32'h200, 0, 32'h11223344, 32'hAABBCCDD,
        32'hDD223344, 0, 3, 1, 0, 0);
    add(OP_LWR, 32'h203, 0, 32'h11223344, 32'hAABBCCDD,
        32'h112233AA, 0, 3, 1, 0, 0);
    add(OP_LWL, 32'h203, 0, 32'h11223344, 32'hAABBCCDD,
        32'hAABBCCDD, 0, 3, 1, 0, 0);
    add(OP_LWR, 32'h200, 0, 32'h11223344, 32'hAABBCCDD,
        32'hAABBCCDD, 0, 3, 1, 0, 0);
    // stores
    add(OP_SB, 32'h101, 32'h000000AA, 0, 32'h11223344,
        0, 0, 4, 1, 1, 32'h1122AA44);
    add(OP_SB, 32'h103, 32'h12345677, 0, 32'h00000000,
        0, 0, 4, 1, 1, 32'h77000000);
    add(OP_SH, 32'h102, 32'hFFFF5566, 0, 32'h11223344,
        0, 0, 4, 1, 1, 32'h55663344);
    add(OP_SH, 32'h100, 32'h0000BEEF, 0, 32'h11223344,
        0, 0, 4, 1, 1, 32'h1122BEEF);
    add(OP_SW, 32'h104, 32'hCAFEF00D, 0, 32'h0,
        0, 0, 2, 0, 1, 32'hCAFEF00D);
    // errors, each after a nonzero result so rdata clearing is visible
    add(OP_LW,  32'h100, 0, 0, 32'h55555555, 32'h55555555, 0, 3, 1, 0, 0);
    add(OP_LH,  32'h003, 0, 0, 32'h12345678, 0, 1, 1, 0, 0, 0);
    add(OP_LW,  32'h102, 0, 0, 32'h12345678, 0, 1, 1, 0, 0, 0);
    add(OP_LHU, 32'h001, 0, 0, 32'h12345678, 0, 1, 1, 0, 0, 0);
    add(OP_SW,  32'h101, 32'h1, 0, 32'h0, 0, 1, 1, 0, 0, 0);
    add(OP_SH,  32'h105, 32'h1, 0, 32'h0, 0, 1, 1, 0, 0, 0);
    add(6'b000000, 32'h100, 0, 0, 32'h0, 0, 1, 1, 0, 0, 0);
    add(6'b101010, 32'h100, 0, 0, 32'h0, 0, 1, 1, 0, 0, 0);
    add(OP_LB, 32'h102, 0, 0, 32'h00FF0000, 32'hFFFFFFFF, 0, 3, 1, 0, 0);

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 32'(bif.req_ready), 32'd0);
    check("rst_resp_valid", 32'(bif.resp_valid), 32'd0);
    check("rst_resp_err", 32'(bif.resp_err), 32'd0);
    check("rst_resp_rdata", bif.resp_rdata, 32'd0);
    check("rst_read", 32'(bif.data_read), 32'd0);
    check("rst_write", 32'(bif.data_write), 32'd0);
    check("rst_addr", bif.data_address, 32'd0);
    check("rst_wdata", bif.data_writedata, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("rst_release_ready", 32'(bif.req_ready), 32'd1);

    for (int i = 0; i < vq.size(); i++) begin
      run_vec(vq[i], i);
    end

    // SH abandoned by reset while in CAP
    @(negedge clk);
    check("abort_ready", 32'(bif.req_ready), 32'd1);
    bif.req_opcode = OP_SH;
    bif.req_addr   = 32'h100;
    bif.req_wdata  = 32'h0000BEEF;
    bif.req_rt_old = 32'h0;
    bif.req_valid  = 1'b1;
    wr_n = 0;
    rs_n = 0;
    @(posedge clk);
    #1;
    bif.req_valid = 1'b0;
    @(negedge clk);
    check("abort_read", 32'(bif.data_read), 32'd1);
    @(posedge clk);
    #1;
    bif.data_readdata = 32'h11223344;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    if (bif.data_write) wr_n++;
    if (bif.resp_valid) rs_n++;
    check("abort_rst_ready", 32'(bif.req_ready), 32'd0);
    check("abort_rst_addr", bif.data_address, 32'd0);
    reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (c == 0) begin
        check("abort_first_ready", 32'(bif.req_ready), 32'd1);
      end
      if (bif.data_write) wr_n++;
      if (bif.resp_valid) rs_n++;
    end
    check("abort_no_write", 32'(wr_n), 32'd0);
    check("abort_no_resp", 32'(rs_n), 32'd0);

    // recovery after the abort
    t = vq[0];
    run_vec(t, 99);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mips_cpu_lsu.md
MIPS_CPU_LSU -- requirements
Module: mips_cpu_lsu

Interface
REQ-001 SHALL have port: clk  in  1  single clock; every register updates on the rising edge.
REQ-002 SHALL have port: reset  in  1  reset is synchronous and active-high.
REQ-003 SHALL have port: req_valid  in  1  the execute stage presents a load/store request.
REQ-004 SHALL have port: req_ready  out  1  the block accepts the request this cycle.
REQ-005 SHALL have port: req_opcode  in  6  MIPS primary opcode: LB 100000, LH 100001, LWL 100010, LW 100011, LBU 100100, LHU 100101, LWR 100110, SB 101000, SH 101001, SW 101011.
REQ-006 SHALL have port: req_addr  in  32  byte address (rs + sign-extended offset).
REQ-007 SHALL have port: req_wdata  in  32  rt value used as store data.
REQ-008 SHALL have port: req_rt_old  in  32  current rt value, used for the LWL/LWR merge.
REQ-009 SHALL have port: resp_valid  out  1  one-cycle completion pulse.
REQ-010 SHALL have port: resp_rdata  out  32  load result for register write-back.
REQ-011 SHALL have port: resp_err  out  1  request was misaligned or had an illegal opcode.
REQ-012 SHALL have port: data_address  out  32  word-aligned memory address.
REQ-013 SHALL have port: data_read  out  1  memory read strobe.
REQ-014 SHALL have port: data_write  out  1  memory write strobe.
REQ-015 SHALL have port: data_writedata  out  32  full-word write data.
REQ-016 SHALL have port: data_readdata  in  32  read data, valid in the cycle after data_read is high.

Function
REQ-017 SHALL implement a state machine with states IDLE, RD, CAP, WR, RESP.
REQ-018 SHALL assert req_ready only in IDLE; the handshake fires when req_valid && req_ready, and opcode, address and data SHALL be latched on that edge.
REQ-019 SHALL drive data_address = {addr[31:2], 2'b00} from the latched address whenever a strobe is high.
REQ-020 SHALL use little-endian byte lanes: byte offset k = addr[1:0] occupies bits [8k+7:8k].
REQ-021 SHALL route each accepted request to its next state as follows: loads and SB/SH go IDLE->RD; SW goes IDLE->WR; errored requests go IDLE->RESP.
REQ-022 SHALL drive data_read=1 for exactly one cycle in RD, then go to CAP.
REQ-023 SHALL, in CAP, sample data_readdata; loads register the result and go to RESP; SB/SH register the merged word and go to WR.
REQ-024 SHALL drive data_write=1 for exactly one cycle in WR, then go to RESP.
REQ-025 SHALL pulse resp_valid for one cycle in RESP, then return to IDLE.
REQ-026 SHALL meet these latencies, accept at cycle N -> resp_valid at: N+3 for loads, N+2 for SW, N+4 for SB/SH, N+1 for errors.
REQ-027 SHALL never assert data_read and data_write together, and SHALL never assert either strobe for an errored request.
REQ-028 SHALL compute load results as follows: LB/LBU sign-/zero-extend byte k; LH/LHU sign-/zero-extend halfword addr[1]; LW returns the whole word.
REQ-029 SHALL compute LWL as (word << 8*(3-k)) | (rt_old & ((1 << 8*(3-k)) - 1)).
REQ-030 SHALL compute LWR as (word >> 8k) | (rt_old & ~(32'hFFFFFFFF >> 8k)).
REQ-031 SHALL replace only the target byte (SB) or halfword (SH) in the merged word; all other bytes SHALL keep their read values.
REQ-032 SHALL flag a misalignment error (resp_err=1, resp_rdata=0) for: LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0. LWL/LWR SHALL never be misaligned.
REQ-033 SHALL treat any opcode not listed in REQ-005 as an error, handled per REQ-032.
REQ-034 SHALL hold resp_rdata and resp_err stable from RESP until the next accepted request.
REQ-035 SHALL, for stores, drive resp_rdata = 0.

Reset
REQ-036 SHALL, while reset=1 at an edge, go to IDLE and set req_ready=0, resp_valid=0, resp_err=0, resp_rdata=0, data_read=0, data_write=0, data_address=0, data_writedata=0.
REQ-037 SHALL, on reset in any state (including RD, CAP or WR), abandon the operation: no write may occur after that edge and no resp_valid may be produced for the abandoned request.
REQ-038 SHALL assert req_ready from the first edge with reset=0.

Verification
REQ-039 SHALL be verified with: LW addr 0x100, memory word 0xDEADBEEF -> data_read at N+1 addr 0x100, resp_valid at N+3, resp_rdata 0xDEADBEEF.
REQ-040 SHALL be verified with: LB addr 0x103, word 0x80112233 -> resp_rdata 0xFFFFFF80; LBU same -> 0x00000080.
REQ-041 SHALL be verified with: SB addr 0x101, wdata 0x000000AA, word 0x11223344 -> data_write at N+3 with data_writedata 0x1122AA44, resp_valid at N+4.
REQ-042 SHALL be verified with: LWL addr 0x201, word 0xAABBCCDD, rt_old 0x11223344 -> 0xCCDD3344; LWR same -> 0x11AABBCC.
REQ-043 SHALL be verified with: LH addr 0x3 -> resp_valid at N+1 with resp_err=1, and no strobe.
REQ-044 SHALL be verified with: SH accepted, reset asserted in CAP -> data_write never asserted, no resp_valid, req_ready=1 on the first edge after reset deasserts.
